// File: rtl/sel_enc_sb.sv
// -----------------------------------------------------------------------------
// sel_enc_sb -- register select/encode unit with write scoreboard
//
// Holds a local copy of the instruction (IR). Each cycle it picks the ra, rb or
// rc field of the IR, with priority Gra > Grb > Grc; with no strobe the index is
// 0. The chosen index is decoded into one-hot register write enables (ctrl_in)
// and bus read enables (ctrl_out), both registered.
//
// A per-register scoreboard tracks writes that are still pending. A read of a
// busy register is suppressed and reported as a one-cycle hazard pulse. Writes
// are never blocked.
//
// Optional feature (macro R0_BASE_EN): a BAout read of R0 is treated as the
// constant zero for address calculation. It produces no read strobe and raises
// base_zero. R0 is also never marked busy. With the macro undefined, BAout acts
// exactly like Rout and base_zero is tied to 0.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   instr_i      instruction from memory data path
//   ir_load_i    capture instr_i into IR at the next edge
//   Gra_i/Grb_i/Grc_i  field select strobes (Gra > Grb > Grc)
//   Rin_i        write-enable request for the selected register
//   Rout_i       read-enable request for the selected register
//   BAout_i      base-address read request
//   issue_i      mark IR.ra as a pending write
//   wb_valid_i   a pending write retires
//   wb_idx_i     index of the retired write
//   ctrl_in_o    registered one-hot write enables
//   ctrl_out_o   registered one-hot read enables
//   sel_idx_o    registered selected index
//   busy_o       scoreboard bits (1 = write pending)
//   hazard_o     registered: a read of a busy register was blocked
//   base_zero_o  registered: BAout hit R0 (R0_BASE_EN only)
// -----------------------------------------------------------------------------
module sel_enc_sb #(
  parameter int NREG    = 16,
  parameter int IDX_W   = $clog2(NREG),
  parameter int INSTR_W = 32,
  parameter int RA_LSB  = 23,
  parameter int RB_LSB  = 19,
  parameter int RC_LSB  = 15
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               ir_load_i,
  input  logic               Gra_i,
  input  logic               Grb_i,
  input  logic               Grc_i,
  input  logic               Rin_i,
  input  logic               Rout_i,
  input  logic               BAout_i,
  input  logic               issue_i,
  input  logic               wb_valid_i,
  input  logic [IDX_W-1:0]   wb_idx_i,
  output logic [NREG-1:0]    ctrl_in_o,
  output logic [NREG-1:0]    ctrl_out_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic [NREG-1:0]    busy_o,
  output logic               hazard_o,
  output logic               base_zero_o
);

  logic [INSTR_W-1:0] ir_q,        ir_d;
  logic [NREG-1:0]    ctrl_in_q,   ctrl_in_d;
  logic [NREG-1:0]    ctrl_out_q,  ctrl_out_d;
  logic [IDX_W-1:0]   sel_idx_q,   sel_idx_d;
  logic [NREG-1:0]    busy_q,      busy_d;
  logic               hazard_q,    hazard_d;
  logic               base_zero_q, base_zero_d;

  logic [IDX_W-1:0] ra, rb, rc, idx;
  logic [NREG-1:0]  onehot;
  logic             rd;
  logic             issue_ok;

  assign ra = ir_q[RA_LSB +: IDX_W];
  assign rb = ir_q[RB_LSB +: IDX_W];
  assign rc = ir_q[RC_LSB +: IDX_W];

  // Decoding always uses the registered IR. An IR load on the same edge is
  // therefore visible only from the following cycle.
  always_comb begin
    idx = '0;
    if      (Gra_i) idx = ra;
    else if (Grb_i) idx = rb;
    else if (Grc_i) idx = rc;
  end

  assign onehot = NREG'(1) << idx;
  assign rd     = Rout_i | BAout_i;

`ifdef R0_BASE_EN
  assign issue_ok = issue_i && (ra != '0);
`else
  assign issue_ok = issue_i;
`endif

  always_comb begin
    ir_d        = ir_load_i ? instr_i : ir_q;
    sel_idx_d   = idx;
    ctrl_in_d   = Rin_i ? onehot : '0;
    ctrl_out_d  = '0;
    hazard_d    = 1'b0;
    base_zero_d = 1'b0;

    // The hazard check looks at busy before this edge updates it.
`ifdef R0_BASE_EN
    if (BAout_i && idx == '0) begin
      base_zero_d = 1'b1;
    end else
`endif
    if (rd && busy_q[idx]) begin
      hazard_d = 1'b1;
    end else if (rd) begin
      ctrl_out_d = onehot;
    end

    // Apply the clear first so that a set to the same index wins.
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_idx_i] = 1'b0;
    if (issue_ok)   busy_d[ra]       = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ir_q        <= '0;
      ctrl_in_q   <= '0;
      ctrl_out_q  <= '0;
      sel_idx_q   <= '0;
      busy_q      <= '0;
      hazard_q    <= 1'b0;
      base_zero_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ctrl_in_q   <= ctrl_in_d;
      ctrl_out_q  <= ctrl_out_d;
      sel_idx_q   <= sel_idx_d;
      busy_q      <= busy_d;
      hazard_q    <= hazard_d;
      base_zero_q <= base_zero_d;
    end
  end

  assign ctrl_in_o   = ctrl_in_q;
  assign ctrl_out_o  = ctrl_out_q;
  assign sel_idx_o   = sel_idx_q;
  assign busy_o      = busy_q;
  assign hazard_o    = hazard_q;
  assign base_zero_o = base_zero_q;

endmodule

// File: tb/tb_sel_enc_sb.sv
module tb_sel_enc_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        ir_load, Gra, Grb, Grc, Rin, Rout, BAout, issue, wb_valid;
  logic [3:0]  wb_idx;
  logic [15:0] ctrl_in, ctrl_out, busy;
  logic [3:0]  sel_idx;
  logic        hazard, base_zero;

  always #5 clk = ~clk;

  sel_enc_sb dut (
    .clk_i(clk), .reset_i(reset), .instr_i(instr), .ir_load_i(ir_load),
    .Gra_i(Gra), .Grb_i(Grb), .Grc_i(Grc), .Rin_i(Rin), .Rout_i(Rout),
    .BAout_i(BAout), .issue_i(issue), .wb_valid_i(wb_valid), .wb_idx_i(wb_idx),
    .ctrl_in_o(ctrl_in), .ctrl_out_o(ctrl_out), .sel_idx_o(sel_idx),
    .busy_o(busy), .hazard_o(hazard), .base_zero_o(base_zero)
  );

  typedef struct packed {
    logic [15:0] cin;
    logic [15:0] cout;
    logic [3:0]  idx;
    logic        hz;
    logic        bz;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_ir;
  logic [15:0] m_busy;
  int          n_chk = 0;
  int          n_err = 0;

  // ra=5 rb=3 rc=9, ra=2 rb=3 rc=9, ra=0 rb=3 rc=9
  localparam logic [31:0] I_A = 32'h029C_8000;
  localparam logic [31:0] I_B = 32'h011C_8000;
  localparam logic [31:0] I_Z = 32'h001C_8000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected response, then pop and
  // compare it one cycle later.
  task automatic step(input logic [31:0] ins, input logic ld,
                      input logic ga, input logic gb, input logic gc,
                      input logic rin, input logic rout, input logic ba,
                      input logic iss, input logic wbv, input logic [3:0] wbi);
    exp_t        e;
    exp_t        g;
    logic [3:0]  ix;
    logic [3:0]  ra;
    logic [15:0] oh;
    logic        rdq;
    instr = ins; ir_load = ld; Gra = ga; Grb = gb; Grc = gc;
    Rin = rin; Rout = rout; BAout = ba; issue = iss; wb_valid = wbv; wb_idx = wbi;
    ra  = m_ir[26:23];
    ix  = ga ? ra : gb ? m_ir[22:19] : gc ? m_ir[18:15] : 4'd0;
    oh  = 16'd1 << ix;
    rdq = rout | ba;
    e.idx = ix;
    e.cin = rin ? oh : 16'd0;
    e.bz  = 1'b0;
    e.hz  = 1'b0;
    e.cout = 16'd0;
`ifdef R0_BASE_EN
    if (ba && ix == 4'd0) e.bz = 1'b1;
    else
`endif
    if (rdq && m_busy[ix]) e.hz = 1'b1;
    else if (rdq) e.cout = oh;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (wbv) m_busy[wbi] = 1'b0;
`ifdef R0_BASE_EN
    if (iss && ra != 4'd0) m_busy[ra] = 1'b1;
`else
    if (iss) m_busy[ra] = 1'b1;
`endif
    if (ld) m_ir = ins;
    g = sb_q.pop_front();
    chk("ctrl_in",   32'(ctrl_in),   32'(g.cin));
    chk("ctrl_out",  32'(ctrl_out),  32'(g.cout));
    chk("sel_idx",   32'(sel_idx),   32'(g.idx));
    chk("hazard",    32'(hazard),    32'(g.hz));
    chk("base_zero", 32'(base_zero), 32'(g.bz));
    chk("busy",      32'(busy),      32'(m_busy));
  endtask

  task automatic idle();
    step(32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_ir = 32'd0;
    m_busy = 16'd0;
    chk("rst_cin",  32'(ctrl_in),  32'd0);
    chk("rst_cout", 32'(ctrl_out), 32'd0);
    chk("rst_idx",  32'(sel_idx),  32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_hz",   32'(hazard),   32'd0);
    chk("rst_bz",   32'(base_zero),32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    instr = '0; ir_load = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
    BAout = 0; issue = 0; wb_valid = 0; wb_idx = '0;
    m_ir = '0; m_busy = '0;
    do_reset();

    // 1: load IR, then Gra+Rin writes R5
    step(I_A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    step(I_A, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'd0);
    chk("t1_cin", 32'(ctrl_in), 32'h0020);

    // 2: Grb+Rout then Grc+Rout back-to-back
    step(I_A, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd0);
    chk("t2_cout_rb", 32'(ctrl_out), 32'h0008);
    step(I_A, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'd0);
    chk("t2_cout_rc", 32'(ctrl_out), 32'h0200);
    chk("t2_idx_rc",  32'(sel_idx),  32'd9);

    // 3: issue R5, blocked read, retire, retry
    step(I_A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    step(I_A, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'd0);
    chk("t3_hz",   32'(hazard), 32'd1);
    chk("t3_busy", 32'(busy),   32'h0020);
    step(I_A, 0, 1, 0, 0, 0, 1, 0, 0, 1, 4'd5);
    chk("t3_hz_wb", 32'(hazard), 32'd1);
    step(I_A, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'd0);
    chk("t3_cout", 32'(ctrl_out), 32'h0020);
    chk("t3_busy0",32'(busy),     32'h0000);

    // Self-copy: Rin and Rout together
    step(I_A, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4'd0);

    // 4: set and clear of the same index: set wins; then independent indices
    step(I_A, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'd5);
    chk("t4_set_wins", 32'(busy), 32'h0020);
    step(I_B, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0); // re-issue busy R5, load ra=2
    step(I_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'd7); // wb on idle index
    chk("t4_busy", 32'(busy), 32'h0024);

    // 5: async reset mid-transfer
    step(I_B, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4'd0);
    chk("t5_pre", 32'(ctrl_out), 32'h0008);
    #2;
    do_reset();

    // 6: BAout of R0
    step(I_Z, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    step(I_Z, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4'd0);
`ifdef R0_BASE_EN
    chk("t6_cout", 32'(ctrl_out),  32'h0000);
    chk("t6_bz",   32'(base_zero), 32'd1);
`else
    chk("t6_cout", 32'(ctrl_out),  32'h0001);
    chk("t6_bz",   32'(base_zero), 32'd0);
`endif
    step(I_Z, 0, 1, 0, 0, 0, 1, 0, 1, 0, 4'd0); // Rout R0 + issue of R0
    step(I_Z, 0, 1, 0, 0, 0, 1, 1, 0, 0, 4'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      step($urandom, r[0], r[1], r[2], r[3], r[4], r[5], r[6] & r[7],
           r[8] & r[9], r[10], r[15:12]);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
